// File: rtl/sdram_axi_memtest_if.sv
// AXI4 master port bundle used by the SDRAM memory tester.
// Master drives the request/payload side; slave drives the ready/response side.
interface sdram_axi_memtest_if;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;

    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;

    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;

    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;

    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;

    modport master (
        output awvalid, awaddr, awlen, awsize, awburst,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bresp,
        output bready,
        output arvalid, araddr, arlen, arsize, arburst,
        input  arready,
        input  rvalid, rdata, rresp, rlast,
        output rready
    );

    modport slave (
        input  awvalid, awaddr, awlen, awsize, awburst,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bresp,
        input  bready,
        input  arvalid, araddr, arlen, arsize, arburst,
        output arready,
        output rvalid, rdata, rresp, rlast,
        input  rready
    );
endinterface

// File: rtl/sdram_axi_memtest.sv
// AXI4 burst memory tester: writes (addr ^ SEED) over a region, reads it back,
// and reports busy/done/pass, a saturating error count and the first failing address.
module sdram_axi_memtest #(
    parameter int unsigned BURST_LEN = 8,
    parameter logic [31:0] SEED      = 32'hA5A5_0000
) (
    input  logic                       ACLK,
    input  logic                       ARSTN,
    input  logic                       start,
    input  logic [31:0]                base_addr,
    input  logic [15:0]                num_bursts,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [15:0]                err_count,
    output logic [31:0]                first_err_addr,
    sdram_axi_memtest_if.master        M00_AXI
);
    localparam logic [7:0]  LP_LAST        = 8'(BURST_LEN - 1);
    localparam logic [31:0] LP_BURST_BYTES = 32'(BURST_LEN * 4);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ADDR,
        S_WR_DATA,
        S_WR_RESP,
        S_RD_ADDR,
        S_RD_DATA,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_base;
    logic [31:0] r_addr;
    logic [15:0] r_nbursts;
    logic [15:0] r_left;
    logic [7:0]  r_beat;
    logic [15:0] r_err_count;
    logic [31:0] r_first_err;

    logic        w_start_ok;
    logic [31:0] w_beat_addr;
    logic [31:0] w_pattern;
    logic        w_last_beat;
    logic        w_final_burst;
    logic        w_aw_hs;
    logic        w_w_hs;
    logic        w_b_hs;
    logic        w_ar_hs;
    logic        w_r_hs;
    logic        w_err_ev;
    logic [31:0] w_err_addr;

    always_comb begin
        w_start_ok    = start && (r_state == S_IDLE || r_state == S_DONE);
        w_beat_addr   = r_addr + {22'd0, r_beat, 2'b00};
        w_pattern     = w_beat_addr ^ SEED;
        w_last_beat   = (r_beat == LP_LAST);
        w_final_burst = (r_left == 16'd1);
        w_aw_hs       = (r_state == S_WR_ADDR) && M00_AXI.awready;
        w_w_hs        = (r_state == S_WR_DATA) && M00_AXI.wready;
        w_b_hs        = (r_state == S_WR_RESP) && M00_AXI.bvalid;
        w_ar_hs       = (r_state == S_RD_ADDR) && M00_AXI.arready;
        w_r_hs        = (r_state == S_RD_DATA) && M00_AXI.rvalid;

        // A read beat counts at most once even if data, response and rlast are all wrong
        w_err_ev   = 1'b0;
        w_err_addr = r_addr;
        if (w_b_hs && M00_AXI.bresp != 2'b00) begin
            w_err_ev = 1'b1;
        end
        if (w_r_hs && (M00_AXI.rdata != w_pattern || M00_AXI.rresp != 2'b00 ||
                       M00_AXI.rlast != w_last_beat)) begin
            w_err_ev   = 1'b1;
            w_err_addr = w_beat_addr;
        end
    end

    always_ff @(posedge ACLK or negedge ARSTN) begin
        if (!ARSTN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next             = r_state;
        M00_AXI.awvalid    = 1'b0;
        M00_AXI.wvalid     = 1'b0;
        M00_AXI.bready     = 1'b0;
        M00_AXI.arvalid    = 1'b0;
        M00_AXI.rready     = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_start_ok) begin
                    w_next = (num_bursts == 16'd0) ? S_DONE : S_WR_ADDR;
                end
            end
            S_WR_ADDR: begin
                M00_AXI.awvalid = 1'b1;
                if (w_aw_hs) w_next = S_WR_DATA;
            end
            S_WR_DATA: begin
                M00_AXI.wvalid = 1'b1;
                if (w_w_hs && w_last_beat) w_next = S_WR_RESP;
            end
            S_WR_RESP: begin
                M00_AXI.bready = 1'b1;
                if (w_b_hs) w_next = w_final_burst ? S_RD_ADDR : S_WR_ADDR;
            end
            S_RD_ADDR: begin
                M00_AXI.arvalid = 1'b1;
                if (w_ar_hs) w_next = S_RD_DATA;
            end
            S_RD_DATA: begin
                M00_AXI.rready = 1'b1;
                if (w_r_hs && w_last_beat) w_next = w_final_burst ? S_DONE : S_RD_ADDR;
            end
            default: w_next = S_IDLE;
        endcase

        // Payloads are forced to zero whenever their valid is low
        M00_AXI.awaddr  = M00_AXI.awvalid ? r_addr : '0;
        M00_AXI.araddr  = M00_AXI.arvalid ? r_addr : '0;
        M00_AXI.wdata   = M00_AXI.wvalid ? w_pattern : '0;
        M00_AXI.wlast   = M00_AXI.wvalid && w_last_beat;
        M00_AXI.awlen   = LP_LAST;
        M00_AXI.arlen   = LP_LAST;
        M00_AXI.awsize  = 3'b010;
        M00_AXI.arsize  = 3'b010;
        M00_AXI.awburst = 2'b01;
        M00_AXI.arburst = 2'b01;
        M00_AXI.wstrb   = 4'hF;
    end

    always_ff @(posedge ACLK or negedge ARSTN) begin
        if (!ARSTN) begin
            r_base      <= '0;
            r_addr      <= '0;
            r_nbursts   <= '0;
            r_left      <= '0;
            r_beat      <= '0;
            r_err_count <= '0;
            r_first_err <= '0;
        end else if (w_start_ok) begin
            r_base      <= base_addr;
            r_addr      <= base_addr;
            r_nbursts   <= num_bursts;
            r_left      <= num_bursts;
            r_beat      <= '0;
            r_err_count <= '0;
            r_first_err <= '0;
        end else begin
            if (w_w_hs || w_r_hs) begin
                r_beat <= w_last_beat ? 8'd0 : r_beat + 8'd1;
            end
            // After the last write burst the address rewinds to base for the read pass
            if (w_b_hs || (w_r_hs && w_last_beat)) begin
                if (w_final_burst) begin
                    r_addr <= r_base;
                    r_left <= r_nbursts;
                end else begin
                    r_addr <= r_addr + LP_BURST_BYTES;
                    r_left <= r_left - 16'd1;
                end
            end
            if (w_err_ev) begin
                if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
                if (r_err_count == 16'd0) r_first_err <= w_err_addr;
            end
        end
    end

    always_comb begin
        busy           = !(r_state == S_IDLE || r_state == S_DONE);
        done           = (r_state == S_DONE);
        pass           = done && (r_err_count == 16'd0);
        err_count      = r_err_count;
        first_err_addr = r_first_err;
    end
endmodule

// File: tb/tb_sdram_axi_memtest.sv
// Directed bench for sdram_axi_memtest: an AXI slave memory model with optional
// stalls and fault injection, checked by immediate assertions in one linear sequence.
module tb_sdram_axi_memtest;
    localparam logic [31:0] SEED = 32'hA5A5_0000;

    logic        ACLK;
    logic        ARSTN;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] num_bursts;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] err_count;
    logic [31:0] first_err_addr;

    sdram_axi_memtest_if bus ();

    sdram_axi_memtest #(
        .BURST_LEN (8),
        .SEED      (SEED)
    ) dut (
        .ACLK           (ACLK),
        .ARSTN          (ARSTN),
        .start          (start),
        .base_addr      (base_addr),
        .num_bursts     (num_bursts),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_err_addr (first_err_addr),
        .M00_AXI        (bus)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    int unsigned cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // slave model configuration and observation
    bit          stall       = 0;
    bit          bresp_err   = 0;
    logic [31:0] corrupt_adr = 32'hFFFF_FFFF;
    logic [31:0] mem [1024];
    logic [31:0] awq [$];
    logic [31:0] arq [$];
    logic [31:0] wq  [$];
    bit          lq  [$];
    int          valid_seen = 0;
    int          stab_bad   = 0;
    int          prot_bad   = 0;
    int          w_cnt      = 0;
    int          b_cnt      = 0;
    int          r_cnt      = 0;
    int unsigned last_r_cyc = 0;
    int unsigned done_cyc   = 0;

    function automatic int unsigned idx(input logic [31:0] a);
        logic [31:0] t;
        t = (a >> 2) & 32'h3FF;
        return int'(t);
    endfunction

    initial begin : slave
        logic        s_awv, s_wv, s_wlast, s_bready, s_arv, s_rready;
        logic [31:0] s_awaddr, s_wdata, s_araddr;
        logic [12:0] s_awcfg, s_arcfg;
        logic [3:0]  s_wstrb;
        bit          h_aw, h_w, h_ar, aw_hs, w_hs, b_hs, ar_hs, r_hs, b_pend, r_act;
        logic [31:0] h_awaddr, h_wdata, h_araddr, wr_ptr, rd_ptr;
        bit          h_wlast;
        int unsigned aw_dly, w_dly, ar_dly, r_dly, r_left;
        h_aw = 0; h_w = 0; h_ar = 0; b_pend = 0; r_act = 0;
        aw_dly = 0; w_dly = 0; ar_dly = 0; r_dly = 0; r_left = 0;
        wr_ptr = '0; rd_ptr = '0; h_awaddr = '0; h_wdata = '0; h_araddr = '0; h_wlast = 0;
        bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = 2'b00;
        bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = 2'b00; bus.rlast = 1'b0;
        forever begin
            @(negedge ACLK);
            s_awv = bus.awvalid; s_awaddr = bus.awaddr;
            s_awcfg = {bus.awlen, bus.awsize, bus.awburst};
            s_wv = bus.wvalid; s_wdata = bus.wdata; s_wlast = bus.wlast; s_wstrb = bus.wstrb;
            s_bready = bus.bready;
            s_arv = bus.arvalid; s_araddr = bus.araddr;
            s_arcfg = {bus.arlen, bus.arsize, bus.arburst};
            s_rready = bus.rready;
            if (s_awv || s_wv || s_arv) valid_seen++;
            if (ARSTN) begin
                if (h_aw && (!s_awv || s_awaddr != h_awaddr)) stab_bad++;
                if (h_w && (!s_wv || s_wdata != h_wdata || s_wlast != h_wlast)) stab_bad++;
                if (h_ar && (!s_arv || s_araddr != h_araddr)) stab_bad++;
            end
            @(posedge ACLK);
            #1;
            if (!ARSTN) begin
                h_aw = 0; h_w = 0; h_ar = 0; b_pend = 0; r_act = 0;
                aw_dly = 0; w_dly = 0; ar_dly = 0; r_dly = 0;
                bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0;
                bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rlast = 1'b0;
            end else begin
                aw_hs = s_awv && bus.awready;
                w_hs  = s_wv && bus.wready;
                b_hs  = bus.bvalid && s_bready;
                ar_hs = s_arv && bus.arready;
                r_hs  = bus.rvalid && s_rready;
                h_aw = s_awv && !bus.awready; h_awaddr = s_awaddr;
                h_w  = s_wv && !bus.wready;   h_wdata = s_wdata; h_wlast = s_wlast;
                h_ar = s_arv && !bus.arready; h_araddr = s_araddr;

                if (aw_hs) begin
                    awq.push_back(s_awaddr);
                    wr_ptr = s_awaddr;
                    if (s_awcfg != {8'd7, 3'd2, 2'd1}) prot_bad++;
                end
                if (w_hs) begin
                    mem[idx(wr_ptr)] = s_wdata;
                    wr_ptr = wr_ptr + 32'd4;
                    wq.push_back(s_wdata);
                    lq.push_back(s_wlast);
                    w_cnt++;
                    if (s_wstrb != 4'hF) prot_bad++;
                    if (s_wlast) b_pend = 1;
                end
                if (b_hs) begin
                    bus.bvalid = 1'b0;
                    b_cnt++;
                end
                if (b_pend && !bus.bvalid) begin
                    bus.bvalid = 1'b1;
                    bus.bresp  = (bresp_err && b_cnt == 0) ? 2'b10 : 2'b00;
                    b_pend = 0;
                end
                if (ar_hs) begin
                    arq.push_back(s_araddr);
                    rd_ptr = s_araddr;
                    r_left = 32'(s_arcfg[12:5]) + 1;
                    r_act  = 1;
                    if (s_arcfg != {8'd7, 3'd2, 2'd1}) prot_bad++;
                end
                if (r_hs) begin
                    r_cnt++;
                    last_r_cyc = cyc;
                    rd_ptr = rd_ptr + 32'd4;
                    r_left--;
                    if (r_left == 0) r_act = 0;
                    bus.rvalid = 1'b0;
                    r_dly = stall ? $urandom_range(0, 5) : 0;
                end
                if (!bus.rvalid && r_act) begin
                    if (r_dly != 0) r_dly--;
                    else begin
                        bus.rvalid = 1'b1;
                        bus.rdata  = mem[idx(rd_ptr)] ^ ((rd_ptr == corrupt_adr) ? 32'd1 : 32'd0);
                        bus.rresp  = 2'b00;
                        bus.rlast  = (r_left == 1);
                    end
                end
                if (aw_hs) aw_dly = stall ? $urandom_range(0, 5) : 0;
                else if (aw_dly != 0) aw_dly--;
                if (w_hs) w_dly = stall ? $urandom_range(0, 5) : 0;
                else if (w_dly != 0) w_dly--;
                if (ar_hs) ar_dly = stall ? $urandom_range(0, 5) : 0;
                else if (ar_dly != 0) ar_dly--;
                bus.awready = (aw_dly == 0);
                bus.wready  = (w_dly == 0);
                bus.arready = (ar_dly == 0);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge ACLK);
            #2;
        end
    endtask

    task automatic clr();
        awq.delete(); arq.delete(); wq.delete(); lq.delete();
        valid_seen = 0; stab_bad = 0; prot_bad = 0;
        w_cnt = 0; b_cnt = 0; r_cnt = 0;
    endtask

    task automatic kick(input logic [31:0] base, input logic [15:0] nb);
        base_addr  = base;
        num_bursts = nb;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        done_cyc = cyc;
        chk("done_reached", {31'd0, done}, 32'd1);
    endtask

    task automatic check_w(input string tag, input logic [31:0] base, input int n);
        int mism;
        mism = 0;
        for (int i = 0; i < n; i++) begin
            if (i >= wq.size() || wq[i] !== ((base + 32'(i * 4)) ^ SEED)) mism++;
        end
        chk(tag, 32'(mism), 32'd0);
    endtask

    function automatic logic [31:0] wlast_mask();
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < lq.size() && i < 32; i++) m[i] = lq[i];
        return m;
    endfunction

    function automatic logic [31:0] idle_outs();
        return {24'd0, bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready,
                busy, done, pass};
    endfunction

    initial begin : main
        ARSTN = 1'b0; start = 1'b0; base_addr = '0; num_bursts = '0;
        step(3);
        chk("rst_ctrl", idle_outs(), 32'd0);
        chk("rst_err", {16'd0, err_count}, 32'd0);
        chk("rst_ferr", first_err_addr, 32'd0);
        chk("rst_addr", bus.awaddr | bus.araddr | bus.wdata, 32'd0);
        ARSTN = 1'b1;
        step(2);

        // ideal slave, two bursts at 0x1000
        clr();
        kick(32'h1000, 16'd2);
        chk("t1_awvalid", {31'd0, bus.awvalid}, 32'd1);
        chk("t1_awaddr", bus.awaddr, 32'h1000);
        chk("t1_awcfg", {19'd0, bus.awlen, bus.awsize, bus.awburst}, {19'd0, 8'd7, 3'd2, 2'd1});
        chk("t1_busy", {31'd0, busy}, 32'd1);
        wait_done(500);
        chk("t1_done_lat", done_cyc, last_r_cyc);
        chk("t1_pass", {31'd0, pass}, 32'd1);
        chk("t1_busy_end", {31'd0, busy}, 32'd0);
        chk("t1_err", {16'd0, err_count}, 32'd0);
        chk("t1_aw_n", 32'(awq.size()), 32'd2);
        chk("t1_aw0", awq[0], 32'h1000);
        chk("t1_aw1", awq[1], 32'h1020);
        chk("t1_w_n", 32'(wq.size()), 32'd16);
        chk("t1_w0", wq[0], 32'hA5A5_1000);
        chk("t1_w1", wq[1], 32'hA5A5_1004);
        check_w("t1_wdata", 32'h1000, 16);
        chk("t1_wlast", wlast_mask(), 32'h0000_8080);
        chk("t1_ar_n", 32'(arq.size()), 32'd2);
        chk("t1_ar1", arq[1], 32'h1020);
        chk("t1_r_n", 32'(r_cnt), 32'd16);
        chk("t1_prot", 32'(prot_bad), 32'd0);

        // corrupted read at 0x1014
        clr();
        corrupt_adr = 32'h1014;
        kick(32'h1000, 16'd2);
        wait_done(500);
        corrupt_adr = 32'hFFFF_FFFF;
        chk("t2_err", {16'd0, err_count}, 32'd1);
        chk("t2_ferr", first_err_addr, 32'h1014);
        chk("t2_pass", {31'd0, pass}, 32'd0);

        // random stalls on every channel
        clr();
        stall = 1;
        kick(32'h2000, 16'd3);
        wait_done(3000);
        stall = 0;
        chk("t3_pass", {31'd0, pass}, 32'd1);
        chk("t3_stable", 32'(stab_bad), 32'd0);
        chk("t3_w_n", 32'(wq.size()), 32'd24);
        check_w("t3_wdata", 32'h2000, 24);
        chk("t3_wlast", wlast_mask(), 32'h0080_8080);
        chk("t3_ar2", arq[2], 32'h2040);
        chk("t3_done_lat", done_cyc, last_r_cyc);

        // error response on the first write burst
        clr();
        bresp_err = 1;
        kick(32'h1000, 16'd2);
        wait_done(500);
        bresp_err = 0;
        chk("t4_err", {16'd0, err_count}, 32'd1);
        chk("t4_ferr", first_err_addr, 32'h1000);
        chk("t4_pass", {31'd0, pass}, 32'd0);
        chk("t4_r_n", 32'(r_cnt), 32'd16);

        // zero bursts
        clr();
        kick(32'h1000, 16'd0);
        chk("t5_done", {31'd0, done}, 32'd1);
        chk("t5_pass", {31'd0, pass}, 32'd1);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        step(5);
        chk("t5_novalid", 32'(valid_seen), 32'd0);

        // start ignored while busy, then reset during write beat 3
        clr();
        kick(32'h1000, 16'd2);
        for (int n = 0; n < 100 && w_cnt < 3; n++) begin
            if (n == 1) begin
                base_addr = 32'h3000; num_bursts = 16'd0; start = 1'b1;
            end else start = 1'b0;
            step();
        end
        start = 1'b0;
        chk("t6_beat3", 32'(w_cnt), 32'd3);
        chk("t6_wvalid_pre", {31'd0, bus.wvalid}, 32'd1);
        chk("t6_wdata_pre", bus.wdata, 32'hA5A5_100C);
        ARSTN = 1'b0;
        #1;
        chk("t6_wvalid_rst", {31'd0, bus.wvalid}, 32'd0);
        chk("t6_ctrl_rst", idle_outs(), 32'd0);
        chk("t6_data_rst", bus.awaddr | bus.araddr | bus.wdata | {31'd0, bus.wlast}, 32'd0);
        chk("t6_err_rst", {16'd0, err_count} | first_err_addr, 32'd0);
        step(2);
        ARSTN = 1'b1;
        step(2);
        clr();
        kick(32'h3000, 16'd1);
        wait_done(500);
        chk("t6_pass", {31'd0, pass}, 32'd1);
        chk("t6_aw0", awq[0], 32'h3000);
        check_w("t6_wdata", 32'h3000, 8);
        chk("t6_r_n", 32'(r_cnt), 32'd8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sdram_axi_memtest.md
Name: sdram_axi_memtest

Overview:
- AXI4 burst master that exercises the SDRAM AXI slave port: writes a deterministic address-derived pattern over a region, then reads it back and compares.
- Sits between a control source (buttons/PS GPIO) and the SDRAM AXI slave, in place of or arbitrated with the PS master.
- Reports busy/done/pass, an error count and the first failing address, for bring-up and board test.

Parameters:
- BURST_LEN, 8, beats per burst (1..256); drives AxLEN = BURST_LEN-1.
- SEED, 32'hA5A5_0000, XOR seed for the data pattern.

Ports:
- ACLK  in  1  clock
- ARSTN  in  1  asynchronous active-low reset
- start  in  1  single-cycle start pulse
- base_addr  in  32  byte address of the first burst, 4-byte aligned, latched on start
- num_bursts  in  16  number of bursts, latched on start
- busy  out  1  test in progress
- done  out  1  test complete; held until next accepted start
- pass  out  1  valid when done; 1 = no errors
- err_count  out  16  errors found, saturating
- first_err_addr  out  32  byte address of the first error
- M00_AXI_awvalid/awready/awaddr[31:0]/awlen[7:0]/awsize[2:0]/awburst[1:0]  AW channel (out/in/out/out/out/out)
- M00_AXI_wvalid/wready/wdata[31:0]/wstrb[3:0]/wlast  W channel (out/in/out/out/out)
- M00_AXI_bvalid/bready/bresp[1:0]  B channel (in/out/in)
- M00_AXI_arvalid/arready/araddr[31:0]/arlen[7:0]/arsize[2:0]/arburst[1:0]  AR channel (out/in/out/out/out/out)
- M00_AXI_rvalid/rready/rdata[31:0]/rresp[1:0]/rlast  R channel (in/out/in/in/in)

Behaviour:
- Reset (async, ARSTN low): state IDLE. All valid/ready outputs are 0, and they drop immediately. busy=0, done=0, pass=0, err_count=0, first_err_addr=0, and all address/data outputs are 0. Reset mid-burst abandons the transaction with no drain.
- Constants: awsize/arsize=3'b010, awburst/arburst=2'b01 (INCR), wstrb=4'hF, awlen/arlen=BURST_LEN-1.
- Pattern: the data for a beat at byte address A is A ^ SEED.
- States and transitions:
  - IDLE: on start, latch inputs, clear err_count/first_err_addr/done/pass, set busy. If num_bursts=0, go to DONE; otherwise go to WR_ADDR.
  - WR_ADDR: awvalid=1 with awaddr = current burst address. On awvalid&awready, go to WR_DATA.
  - WR_DATA: wvalid=1 and wdata follows the pattern. A beat advances only on wvalid&wready. wlast=1 exactly on beat BURST_LEN-1. After the last beat, go to WR_RESP.
  - WR_RESP: bready=1. On bvalid, if bresp!=0 record an error at the burst address. Then advance the burst address by BURST_LEN*4. Go to WR_ADDR if bursts remain; otherwise reset the address to base and go to RD_ADDR.
  - RD_ADDR: arvalid=1. On arvalid&arready, go to RD_DATA.
  - RD_DATA: rready=1. On each rvalid, compare rdata with the expected pattern. A mismatch, rresp!=0, or rlast disagreeing with (beat==BURST_LEN-1) is one error at that beat address. After the final beat, advance as in WR_RESP; go to RD_ADDR if bursts remain, otherwise DONE.
  - DONE: busy=0, done=1, pass=(err_count==0). On start, behave as IDLE.
- Only one outstanding transaction at a time; W follows AW and never overlaps it.
- Once asserted, valid and payload stay stable until the handshake completes (AXI rule).
- Recording an error: err_count increments and saturates at 16'hFFFF. first_err_addr is written only on the first error (err_count==0 before the increment).
- start is ignored while busy.
- Address arithmetic is 32-bit and wraps modulo 2^32, with no 4KB boundary check. The caller keeps BURST_LEN*4 bursts within 4KB by choosing an aligned base_addr.
- Latency: awvalid rises in the cycle after start is sampled. done rises in the cycle after the final read beat.

Test Plan:
- BURST_LEN=8, base=0x1000, num_bursts=2, ideal slave memory model -> 2 AW at 0x1000/0x1020 with awlen=7; 16 W beats with wdata=0xA5A51000,0xA5A51004,...; wlast on beats 7/15; 2 AR; done=1, pass=1, err_count=0.
- Same setup, but the model corrupts the read of 0x1014 (bit 0 flipped) -> err_count=1, first_err_addr=0x1014, pass=0.
- Random wready/arready/rvalid/awready stalls (0-5 cycles) -> beat sequence and payload stable under backpressure; pass=1.
- bresp=2'b10 on the first burst -> err_count=1, first_err_addr=0x1000, and the read phase still completes.
- num_bursts=0 -> no AXI valid ever asserted; done=1, pass=1 one cycle after start.
- ARSTN low during WR_DATA beat 3 -> wvalid=0 immediately and all outputs at reset values; a subsequent start reruns the test cleanly.
